// File: rtl/gcd_scheduler.sv
// Round-robin scheduler in front of a single shared subtractive GCD engine.
// One job is in flight at a time: IDLE grants a requester, CALC iterates
// and RESP holds the result until the consumer takes it.
module gcd_scheduler #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IdW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_gcd,
  output logic                     busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;

  logic             gnt_found;
  logic [IdW-1:0]   gnt_idx;
  logic [IdW-1:0]   cand;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             calc_done;

  // Round-robin pick: first asserted request at or after rr_ptr, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Only the winner sees ready, and only in IDLE outside reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_a     = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
  assign sel_b     = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
  assign calc_done = (a_q == b_q) || (a_q == '0) || (b_q == '0);

  // Next-state: accept in IDLE, one subtraction per CALC cycle, hold in RESP.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    gcd_d    = gcd_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          a_d      = sel_a;
          b_d      = sel_b;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (calc_done) begin
          // Zero operand: the other one is the answer (covers gcd(0,0)=0).
          gcd_d    = (a_q == '0) ? b_q : a_q;
          rsp_id_d = id_q;
          state_d  = StResp;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      gcd_q    <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      gcd_q    <= gcd_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_id    = rsp_id_q;
  assign rsp_gcd   = gcd_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Scoreboard bench for gcd_scheduler: the monitor predicts grants and
// results from a round-robin + Euclid reference and checks every response.
module tb_gcd_scheduler;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_gcd;
  logic           busy;

  gcd_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gcd   (rsp_gcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [31:0] gcd;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_done = 0;
  bit          inflight = 0;
  bit          seen = 0;
  int unsigned lat_ctr = 0;
  int          rr_m = 0;
  logic [N-1:0] last_gnt = '0;
  logic [31:0] last_gcd = '0;
  logic [31:0] last_id = '0;

  // Euclid with modulo: independent of how the engine iterates.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractions needed before the operands meet (sets the latency).
  function automatic int unsigned sub_steps(input logic [31:0] a, input logic [31:0] b);
    int unsigned n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: grant prediction, busy, latency, response and hold checks.
  bit          was;
  int          exp_idx;
  logic [N-1:0] exp_rdy;
  logic [31:0] ea, eb;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      inflight = 0;
      seen     = 0;
      rr_m     = 0;
      last_gnt = '0;
      last_gcd = '0;
      last_id  = '0;
    end else begin
      was = inflight;
      if (was) lat_ctr++;
      check("busy", 32'(busy), 32'(was));
      exp_idx = -1;
      exp_rdy = '0;
      if (!was) begin
        for (int k = 0; k < N; k++) begin
          if (exp_idx < 0 && req_valid[(rr_m + k) % N]) exp_idx = (rr_m + k) % N;
        end
        if (exp_idx >= 0) exp_rdy[exp_idx] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      last_gnt = req_ready & req_valid;
      if (!was) begin
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        check("hold_gcd", rsp_gcd, last_gcd);
        check("hold_id", 32'(rsp_id), last_id);
        if (exp_idx >= 0 && last_gnt != '0) begin
          ea = req_a[exp_idx*W +: W];
          eb = req_b[exp_idx*W +: W];
          sb.push_back('{id: exp_idx, gcd: ref_gcd(ea, eb), lat: 2 + sub_steps(ea, eb)});
          gnt_log.push_back(exp_idx);
          inflight = 1;
          seen     = 0;
          lat_ctr  = 0;
          rr_m     = (exp_idx + 1) % N;
        end
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          if (!seen) begin
            check("latency", lat_ctr, sb[0].lat);
            seen = 1;
          end
          check("rsp_id", 32'(rsp_id), sb[0].id);
          check("rsp_gcd", rsp_gcd, sb[0].gcd);
          if (rsp_ready) begin
            last_gcd = sb[0].gcd;
            last_id  = sb[0].id;
            void'(sb.pop_front());
            inflight = 0;
            n_done++;
          end
        end
      end else begin
        check("hold_gcd_calc", rsp_gcd, last_gcd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_gnt;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid[r]    = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((req_valid != '0 || inflight) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n >= budget), 0);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int g0, d0, n_iss, budget;
  int order2[4] = '{1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_gcd", rsp_gcd, 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;

    // Basic result, then equal and zero operands.
    issue(0, 14, 161);
    wait_idle("to_14_161", 500);
    issue(1, 12, 12);
    wait_idle("to_12_12", 50);
    issue(1, 0, 25);
    wait_idle("to_0_25", 50);
    issue(1, 0, 0);
    wait_idle("to_0_0", 50);

    // Round-robin ordering from a fresh reset.
    pulse_reset();
    g0 = gnt_log.size();
    issue(0, 8, 12);
    issue(2, 9, 6);
    wait_idle("to_pair", 200);
    check("order_len1", 32'(gnt_log.size() - g0), 2);
    if (gnt_log.size() - g0 == 2) begin
      check("order1_0", 32'(gnt_log[g0]), 0);
      check("order1_1", 32'(gnt_log[g0+1]), 2);
    end
    issue(0, 5, 10);
    wait_idle("to_ptr1", 200);
    g0 = gnt_log.size();
    for (int r = 0; r < N; r++) issue(r, 6 * (r + 1), 4);
    wait_idle("to_round2", 500);
    check("order_len2", 32'(gnt_log.size() - g0), 4);
    if (gnt_log.size() - g0 == 4) begin
      for (int i = 0; i < 4; i++) check("order2", 32'(gnt_log[g0+i]), 32'(order2[i]));
    end

    // Backpressure on the response while another request waits.
    rsp_ready = 1'b0;
    issue(1, 100, 75);
    budget = 0;
    while (req_valid != '0 && budget < 100) begin tick(); budget++; end
    issue(3, 7, 21);
    budget = 0;
    while (!rsp_valid && budget < 100) begin tick(); budget++; end
    check("to_rsp_100_75", 32'(budget >= 100), 0);
    repeat (10) tick();
    check("bp_valid", 32'(rsp_valid), 1);
    check("bp_gcd", rsp_gcd, 25);
    check("bp_pending", 32'(req_valid[3]), 1);
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_valid", 32'(rsp_valid), 0);
    check("bp_idle_busy", 32'(busy), 0);
    wait_idle("to_bp", 200);

    // Asynchronous reset in the middle of a long computation.
    d0 = n_done;
    issue(0, 1000, 1);
    repeat (20) tick();
    check("abort_busy_before", 32'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rsp_gcd", rsp_gcd, 0);
    check("arst_rsp_id", 32'(rsp_id), 0);
    tick();
    issue(0, 1000, 1);
    #1;
    check("arst_req_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    wait_idle("to_reissue", 3000);
    check("reissue_count", 32'(n_done - d0), 1);
    check("reissue_gcd", last_gcd, 1);

    // Randomised traffic with random consumer backpressure.
    d0     = n_done;
    n_iss  = 0;
    budget = 0;
    while ((n_iss < 100 || req_valid != '0 || inflight) && budget < 80000) begin
      tick();
      budget++;
      rsp_ready = ($urandom % 4) != 0;
      if (n_iss < 100 && ($urandom % 3) == 0) begin
        int r;
        r = int'($urandom % N);
        if (!req_valid[r]) begin
          issue(r, $urandom_range(10, 1000), $urandom_range(10, 1000));
          n_iss++;
        end
      end
    end
    check("to_random", 32'(budget >= 80000), 0);
    rsp_ready = 1'b1;
    tick();
    check("rand_done", 32'(n_done - d0), 100);
    check("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
